uart_tx_queue: RTL and testbench

Transmit-side byte queue that sits directly upstream of `uart_core`. It buffers bytes from a producer on a valid/ready stream and launches them one at a time into the core's transmitter. Each launch is gated by the `cts` flow-control line and paced by the core's busy indication. A short inter-frame gap is enforced between launches.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_queue.sv | 141 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } tx_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with flush; level is a separate 0..DEPTH counter.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    // Full blocks a push even when a pop lands in the same cycle (no fall-through).
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding uart_core: cts-gated launches, busy pacing,
// launch timeout and a fixed inter-frame gap.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int BIT_CLK = 8,
    parameter int GAP_CLK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [UART_DATA_W-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     cts,
    output logic [UART_DATA_W-1:0]   core_txdata,
    output logic                     core_start,
    input  logic                     core_busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     tx_timeout
);

    localparam int TO_CLK  = 2 * BIT_CLK;
    localparam int TMR_MAX = max_int(TO_CLK, GAP_CLK);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    // Timeout window is measured from the start strobe, so the LAUNCH cycle counts.
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TO_CLK - 2);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CLK - 1);

    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [TMR_W-1:0]       r_timer;
    logic [TMR_W-1:0]       w_timer_nxt;
    logic                   r_core_start;
    logic [UART_DATA_W-1:0] r_core_txdata;
    logic                   r_tx_timeout;
    logic                   w_launch;
    logic                   w_pop;
    logic                   w_timeout_hit;
    logic                   w_full;
    logic                   w_empty;
    logic [UART_DATA_W-1:0] w_head;

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_data  (in_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign in_ready    = !w_full;
    assign core_start  = r_core_start;
    assign core_txdata = r_core_txdata;
    assign tx_timeout  = r_tx_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_launch      = 1'b0;
        w_pop         = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                // A flush in the same cycle wins over a launch.
                if (!w_empty && cts && !flush) begin
                    w_launch    = 1'b1;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_pop       = 1'b1;
                w_timer_nxt = TO_LOAD;
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (core_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_timer == '0) begin
                    w_timeout_hit = 1'b1;
                    w_timer_nxt   = GAP_LOAD;
                    w_state_nxt   = GAP;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!core_busy) begin
                    w_timer_nxt = GAP_LOAD;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (r_timer == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_start  <= 1'b0;
            r_core_txdata <= '0;
            r_tx_timeout  <= 1'b0;
        end else begin
            r_core_start <= w_launch;
            if (w_launch) begin
                r_core_txdata <= w_head;
            end
            if (w_timeout_hit) begin
                r_tx_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed and random stimulus for uart_tx_queue against a queue-based reference
// model with a behavioural uart_core busy responder.
module tb_uart_tx_queue;

    localparam int DEPTH   = 16;
    localparam int BIT_CLK = 8;
    localparam int GAP_CLK = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic       cts = 1'b0;
    logic [7:0] core_txdata;
    logic       core_start;
    logic       core_busy = 1'b0;
    logic [4:0] level;
    logic       tx_timeout;

    uart_tx_queue #(
        .DEPTH   (DEPTH),
        .BIT_CLK (BIT_CLK),
        .GAP_CLK (GAP_CLK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .cts         (cts),
        .core_txdata (core_txdata),
        .core_start  (core_start),
        .core_busy   (core_busy),
        .level       (level),
        .tx_timeout  (tx_timeout)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0] mq[$];
    logic [7:0] exp_txd = 8'h00;
    bit   exp_to = 1'b0;
    bit   pending_to = 1'b0;
    int   to_deadline = 0;
    bit   pop_pend = 1'b0;
    bit   init_done = 1'b0;
    int   cyc = 0;
    int   n_starts = 0;
    bit   prev_start = 1'b0;
    int   last_start = -1000;
    int   last_fall = -1000;
    bit   have_fall = 1'b0;
    int   start_log[$];
    int   start_gap[$];
    logic [7:0] data_log[$];

    // uart_core responder
    bit busy_en = 1'b1;
    bit busy_rand = 1'b0;
    bit busy_arm = 1'b0;
    int busy_left = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit acc, cts_s, flush_s, rst_s;
        logic [7:0] din_s;
        int g;
        acc     = in_valid && !rst && !flush && (mq.size() < DEPTH);
        cts_s   = cts;
        flush_s = flush;
        rst_s   = rst;
        din_s   = in_data;
        if (init_done) chk("in_ready", in_ready, mq.size() < DEPTH);
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            mq.delete();
            exp_to = 1'b0; pending_to = 1'b0; have_fall = 1'b0;
            exp_txd = 8'h00; init_done = 1'b1;
        end else if (flush_s) begin
            mq.delete();
        end else begin
            if (pop_pend && mq.size() > 0) void'(mq.pop_front());
            if (acc) mq.push_back(din_s);
        end
        pop_pend = 1'b0;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                core_busy = 1'b0;
                last_fall = cyc;
                have_fall = 1'b1;
            end
        end
        if (busy_arm && busy_en) begin
            core_busy  = 1'b1;
            busy_left  = busy_rand ? $urandom_range(1, 3*BIT_CLK) : 10*BIT_CLK;
            pending_to = 1'b0;
        end
        if (pending_to && cyc == to_deadline) begin
            exp_to = 1'b1;
            pending_to = 1'b0;
        end
        if (init_done) begin
            if (core_start) begin
                n_starts++;
                chk("start_pulse", prev_start, 0);
                chk("start_cts", cts_s, 1);
                chk("start_flush", flush_s, 0);
                chk("start_rst", rst_s, 0);
                chk("start_nonempty", mq.size() != 0, 1);
                if (mq.size() != 0) exp_txd = mq[0];
                if (have_fall && last_fall > last_start) begin
                    g = cyc - last_fall;
                    chk("gap_min", g >= GAP_CLK + 2, 1);
                end else begin
                    g = -1;
                end
                start_gap.push_back(g);
                start_log.push_back(cyc);
                data_log.push_back(core_txdata);
                last_start  = cyc;
                pop_pend    = 1'b1;
                pending_to  = 1'b1;
                to_deadline = cyc + 2*BIT_CLK;
            end
            chk("level", level, mq.size());
            chk("txdata", core_txdata, exp_txd);
            chk("tx_timeout", tx_timeout, exp_to);
        end
        busy_arm   = core_start;
        prev_start = core_start;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input int budget, input string tag, output int c);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!core_start && n < budget);
        chk(tag, core_start, 1);
        c = cyc;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},   in_ready, 1);
        chk({tag, "_txdata"},  core_txdata, 8'h00);
        chk({tag, "_start"},   core_start, 0);
        chk({tag, "_level"},   level, 0);
        chk({tag, "_timeout"}, tx_timeout, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, s, s2, s0, b, n;

        // reset
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        check_reset_vals("reset");

        // single byte: valid presented in cycle k, start high in cycle k+2
        cts = 1'b1;
        push(8'h77);
        p = cyc;
        wait_start(10, "single_start", s);
        chk("single_latency", s - p, 1);
        chk("single_data", core_txdata, 8'h77);
        run(10*BIT_CLK + GAP_CLK + 10);
        chk("single_count", n_starts, 1);
        chk("single_level", level, 0);

        // burst fill with cts low, 17th byte refused
        cts = 1'b0;
        for (int i = 0; i < 17; i++) begin
            chk("burst_ready", in_ready, i < 16);
            push(8'(i));
        end
        chk("burst_level", level, 16);
        chk("burst_full", in_ready, 0);
        b  = data_log.size();
        s0 = n_starts;
        cts = 1'b1;
        n = 0;
        while (n_starts - s0 < 16 && n < 4000) begin
            tick();
            n++;
        end
        chk("burst_count", n_starts - s0, 16);
        for (int i = 0; i < 16; i++) begin
            if (b + i < data_log.size()) begin
                chk("burst_order", data_log[b+i], 8'(i));
                if (i > 0) chk("burst_gap", start_gap[b+i], GAP_CLK + 2);
            end
        end
        run(10*BIT_CLK + GAP_CLK + 10);
        chk("burst_drained", level, 0);

        // flow control: cts drop mid-frame holds the second byte
        cts = 1'b0;
        push(8'haa);
        push(8'h33);
        cts = 1'b1;
        wait_start(10, "flow_start", s);
        chk("flow_first", core_txdata, 8'haa);
        s0 = n_starts;
        run(3);
        cts = 1'b0;
        run(10*BIT_CLK + GAP_CLK + 20);
        chk("flow_hold", n_starts - s0, 0);
        chk("flow_level", level, 1);
        cts = 1'b1;
        wait_start(10, "flow_resume", s);
        chk("flow_second", core_txdata, 8'h33);
        run(10*BIT_CLK + GAP_CLK + 10);

        // flush during WAIT_DONE
        cts = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(i));
        cts = 1'b1;
        wait_start(10, "flush_start", s);
        chk("flush_first", core_txdata, 8'h01);
        run(5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_level", level, 0);
        s0 = n_starts;
        run(10*BIT_CLK + GAP_CLK + 20);
        chk("flush_no_start", n_starts - s0, 0);
        chk("flush_busy_done", core_busy, 0);

        // timeout: busy never arrives for the first frame
        busy_en = 1'b0;
        cts = 1'b0;
        push(8'h5a);
        push(8'h5b);
        cts = 1'b1;
        wait_start(10, "to_start", s);
        run(2*BIT_CLK - 1);
        chk("to_before", tx_timeout, 0);
        tick();
        chk("to_at", tx_timeout, 1);
        chk("to_delay", cyc - s, 2*BIT_CLK);
        busy_en = 1'b1;
        wait_start(GAP_CLK + 10, "to_relaunch", s2);
        chk("to_relaunch_time", s2 - s, 2*BIT_CLK + GAP_CLK + 1);
        chk("to_next_data", core_txdata, 8'h5b);
        run(10*BIT_CLK + GAP_CLK + 10);
        chk("to_sticky", tx_timeout, 1);

        // reset in WAIT_DONE with three bytes still queued
        cts = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hc1 + 8'(i));
        cts = 1'b1;
        wait_start(10, "rstmid_start", s);
        run(5);
        chk("rstmid_level", level, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("rstmid");
        s0 = n_starts;
        run(10*BIT_CLK + GAP_CLK + 20);
        chk("rstmid_busy_done", core_busy, 0);
        chk("rstmid_no_start", n_starts - s0, 0);

        // random traffic against the reference model
        busy_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            cts      = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 63) == 0);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        cts = 1'b1;
        n = 0;
        while (mq.size() != 0 && n < 4000) begin
            tick();
            n++;
        end
        run(3*BIT_CLK + GAP_CLK + 10);
        chk("rand_drain", level, 0);
        chk("rand_idle_busy", core_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
